reset_req_sequencer: RTL and testbench



---
 rtl/reset_req_sequencer_if.sv | 23 ++
 rtl/reset_req_sequencer.sv | 122 ++++++++++++
 tb/tb_reset_req_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/reset_req_sequencer_if.sv
// Request/acknowledge/reset-output bundle between the reset sequencer and its surroundings.
interface reset_req_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  io_req_sw;
    logic                  io_req_wdt;
    logic                  io_req_ext;
    logic [NUM_STAGES-1:0] io_ack;
    logic [NUM_STAGES-1:0] io_rst_out;
    logic                  io_busy;
    logic [2:0]            io_cause;
    logic                  io_timeout;

    modport master (
        output io_req_sw, io_req_wdt, io_req_ext, io_ack,
        input  io_rst_out, io_busy, io_cause, io_timeout
    );

    modport slave (
        input  io_req_sw, io_req_wdt, io_req_ext, io_ack,
        output io_rst_out, io_busy, io_cause, io_timeout
    );
endinterface

// File: rtl/reset_req_sequencer.sv
// Turns reset requests into stretched, staged reset outputs released one domain
// at a time, each release gated by the previous domain's ack or a timeout.
module reset_req_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    reset_req_sequencer_if.slave   bus
);
    localparam int MAX_A   = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_CNT = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int SW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CNT);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] TMO_END  = CW'(ACK_TIMEOUT);
    localparam logic [SW-1:0] LAST     = SW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK, GAP} state_t;

    state_t                  state, state_nxt;
    logic [SW-1:0]           stage, stage_nxt, stage_inc;
    logic [CW-1:0]           cnt, cnt_nxt, cnt_inc;
    logic [NUM_STAGES-1:0]   rst_q, rst_nxt;
    logic                    busy_q, busy_nxt;
    logic [2:0]              cause_q, cause_nxt, req_vec;
    logic                    tmo_q, tmo_nxt;
    logic                    req_any, ack_hit, ack_due;

    assign req_vec   = {bus.io_req_ext, bus.io_req_wdt, bus.io_req_sw};
    assign req_any   = |req_vec;
    assign stage_inc = stage + 1'b1;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    // WAIT_ACK only runs for a stage already released, so ack is never sampled while held.
    assign ack_hit   = bus.io_ack[stage];
    assign ack_due   = (cnt >= TMO_END);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ASSERT;
            stage   <= '0;
            cnt     <= '0;
            rst_q   <= '1;
            busy_q  <= 1'b1;
            cause_q <= 3'b000;
            tmo_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            stage   <= stage_nxt;
            cnt     <= cnt_nxt;
            rst_q   <= rst_nxt;
            busy_q  <= busy_nxt;
            cause_q <= cause_nxt;
            tmo_q   <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        cnt_nxt   = cnt_inc;
        rst_nxt   = rst_q;
        cause_nxt = cause_q;
        tmo_nxt   = tmo_q;
        if (req_any) begin
            state_nxt = ASSERT;
            stage_nxt = '0;
            cnt_nxt   = '0;
            rst_nxt   = '1;
            cause_nxt = req_vec;
            tmo_nxt   = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ASSERT: begin
                    if (cnt >= HOLD_END) begin
                        rst_nxt[0] = 1'b0;
                        stage_nxt  = '0;
                        state_nxt  = WAIT_ACK;
                        cnt_nxt    = '0;
                    end
                end
                WAIT_ACK: begin
                    if (ack_hit || ack_due) begin
                        if (!ack_hit) tmo_nxt = 1'b1;
                        if (stage == LAST) begin
                            state_nxt = IDLE;
                        end else if (STAGE_GAP == 1) begin
                            stage_nxt          = stage_inc;
                            rst_nxt[stage_inc] = 1'b0;
                            cnt_nxt            = '0;
                        end else begin
                            // gap count includes the acceptance cycle
                            state_nxt = GAP;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                GAP: begin
                    if (cnt >= GAP_END) begin
                        stage_nxt          = stage_inc;
                        rst_nxt[stage_inc] = 1'b0;
                        state_nxt          = WAIT_ACK;
                        cnt_nxt            = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.io_rst_out = rst_q;
    assign bus.io_busy    = busy_q;
    assign bus.io_cause   = cause_q;
    assign bus.io_timeout = tmo_q;
endmodule

// File: tb/tb_reset_req_sequencer.sv
// Checkpoint table for directed sequences plus a schedule-based reference model for random traffic.
module tb_reset_req_sequencer;
    localparam int NS   = 3;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reset_req_sequencer_if #(.NUM_STAGES(NS)) bus ();

    reset_req_sequencer #(
        .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .ACK_TIMEOUT(TMO)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    typedef struct {
        int          scen;
        int          cyc;
        logic [2:0]  rst_out;
        logic        busy;
        logic [2:0]  cause;
        logic        tmo;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: expected outputs for the current cycle plus a release schedule.
    logic [NS-1:0] m_rst;
    logic          m_busy;
    logic [2:0]    m_cause;
    logic          m_tmo;
    int            next_rel = -1;
    int            rel_idx  = 0;
    bit            waiting  = 0;
    int            wait_idx = 0;
    int            t0       = 0;

    function automatic void add_vec(int s, int c, logic [2:0] r, logic b, logic [2:0] ca, logic t);
        vec_t v;
        v.scen = s; v.cyc = c; v.rst_out = r; v.busy = b; v.cause = ca; v.tmo = t;
        vecs.push_back(v);
    endfunction

    // Inputs seen during cycle c decide the outputs of cycle c+1.
    task automatic model_step(input int c, input logic rin, input logic [2:0] req, input logic [NS-1:0] ack);
        if (rin || req != 3'b000) begin
            m_rst    = '1;
            m_busy   = 1'b1;
            m_cause  = rin ? 3'b000 : req;
            m_tmo    = 1'b0;
            waiting  = 0;
            rel_idx  = 0;
            next_rel = c + 1 + HOLD;
        end else if (waiting && (ack[wait_idx] || c >= t0 + TMO)) begin
            if (!ack[wait_idx]) m_tmo = 1'b1;
            waiting = 0;
            if (wait_idx == NS - 1) begin
                m_busy   = 1'b0;
                next_rel = -1;
            end else begin
                rel_idx  = wait_idx + 1;
                next_rel = c + GAP;
            end
        end
        if (!waiting && next_rel == c + 1) begin
            m_rst[rel_idx] = 1'b0;
            waiting  = 1;
            wait_idx = rel_idx;
            t0       = c + 1;
            next_rel = -1;
        end
    endtask

    task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got rst/busy/cause/tmo=%b required=%b", name, c, act, exp);
        end
    endtask

    task automatic run_scen(input int scen, input int last);
        logic [NS-1:0] hist1, hist2, ack, mode_ack;
        logic [2:0]    req;
        logic          rin;
        logic [7:0]    act;
        int            mode [NS];
        hist1 = '1;
        hist2 = '1;
        for (int i = 0; i < NS; i++) mode[i] = 1;
        for (int c = -2; c <= last; c++) begin
            @(posedge clk);
            #1;
            act = {bus.io_rst_out, bus.io_busy, bus.io_cause, bus.io_timeout};
            if (c >= -1) check("model", c, act, {m_rst, m_busy, m_cause, m_tmo});
            foreach (vecs[k])
                if (vecs[k].scen == scen && vecs[k].cyc == c)
                    check("vector", c, act,
                          {vecs[k].rst_out, vecs[k].busy, vecs[k].cause, vecs[k].tmo});
            rin = (c < 0) || (scen == 5 && c == 30);
            req = 3'b000;
            if (scen == 3 && c == 30) req = 3'b011;
            if (scen == 4 && c == 22) req = 3'b100;
            if (scen == 5 && c == 30) req = 3'b001;
            case (scen)
                1:       ack = ~hist2;
                2, 5:    ack = 3'b101;
                6: begin
                    if (c % 64 == 0)
                        for (int i = 0; i < NS; i++) mode[i] = $urandom_range(0, 2);
                    for (int i = 0; i < NS; i++)
                        mode_ack[i] = (mode[i] == 2) ? ($urandom_range(0, 3) == 0) : (mode[i] == 1);
                    ack = mode_ack;
                    if (c >= 0) begin
                        rin = ($urandom_range(0, 599) == 0);
                        req = {($urandom_range(0, 199) == 0), ($urandom_range(0, 199) == 0),
                               ($urandom_range(0, 199) == 0)};
                    end
                end
                default: ack = 3'b111;
            endcase
            hist2 = hist1;
            hist1 = bus.io_rst_out;
            rst            = rin;
            bus.io_req_sw  = req[0];
            bus.io_req_wdt = req[1];
            bus.io_req_ext = req[2];
            bus.io_ack     = ack;
            model_step(c, rin, req, ack);
        end
    endtask

    initial begin
        // scen, cycle, rst_out, busy, cause, timeout
        add_vec(0, -1, 3'b111, 1, 3'b000, 0);
        add_vec(0,  0, 3'b111, 1, 3'b000, 0);
        add_vec(0, 15, 3'b111, 1, 3'b000, 0);
        add_vec(0, 16, 3'b110, 1, 3'b000, 0);
        add_vec(0, 19, 3'b110, 1, 3'b000, 0);
        add_vec(0, 20, 3'b100, 1, 3'b000, 0);
        add_vec(0, 23, 3'b100, 1, 3'b000, 0);
        add_vec(0, 24, 3'b000, 1, 3'b000, 0);
        add_vec(0, 25, 3'b000, 0, 3'b000, 0);
        add_vec(1, 16, 3'b110, 1, 3'b000, 0);
        add_vec(1, 21, 3'b110, 1, 3'b000, 0);
        add_vec(1, 22, 3'b100, 1, 3'b000, 0);
        add_vec(1, 27, 3'b100, 1, 3'b000, 0);
        add_vec(1, 28, 3'b000, 1, 3'b000, 0);
        add_vec(1, 30, 3'b000, 1, 3'b000, 0);
        add_vec(1, 31, 3'b000, 0, 3'b000, 0);
        add_vec(2, 20, 3'b100, 1, 3'b000, 0);
        add_vec(2, 84, 3'b100, 1, 3'b000, 0);
        add_vec(2, 85, 3'b100, 1, 3'b000, 1);
        add_vec(2, 87, 3'b100, 1, 3'b000, 1);
        add_vec(2, 88, 3'b000, 1, 3'b000, 1);
        add_vec(2, 89, 3'b000, 0, 3'b000, 1);
        add_vec(3, 30, 3'b000, 0, 3'b000, 0);
        add_vec(3, 31, 3'b111, 1, 3'b011, 0);
        add_vec(3, 46, 3'b111, 1, 3'b011, 0);
        add_vec(3, 47, 3'b110, 1, 3'b011, 0);
        add_vec(4, 22, 3'b100, 1, 3'b000, 0);
        add_vec(4, 23, 3'b111, 1, 3'b100, 0);
        add_vec(4, 38, 3'b111, 1, 3'b100, 0);
        add_vec(4, 39, 3'b110, 1, 3'b100, 0);
        add_vec(5, 30, 3'b100, 1, 3'b000, 0);
        add_vec(5, 31, 3'b111, 1, 3'b000, 0);
        add_vec(5, 46, 3'b111, 1, 3'b000, 0);
        add_vec(5, 47, 3'b110, 1, 3'b000, 0);
        add_vec(5, 51, 3'b100, 1, 3'b000, 0);

        bus.io_req_sw  = 1'b0;
        bus.io_req_wdt = 1'b0;
        bus.io_req_ext = 1'b0;
        bus.io_ack     = '0;

        run_scen(0, 30);
        run_scen(1, 35);
        run_scen(2, 92);
        run_scen(3, 50);
        run_scen(4, 42);
        run_scen(5, 55);
        run_scen(6, 4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
